// File: rtl/auto_script_sequencer_if.sv
// Script sequencer bundle: mode/pause requests, MK9 ROM port and car drive outputs.
`timescale 1ns/1ps
interface auto_script_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic              auto_req;
    logic              pause;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic [2:0]        car_sw;
    logic [1:0]        car_key;
    logic              auto_active;
    logic              step_pulse;
    logic              loop_done;

    modport slave (
        input  auto_req, pause, rom_q,
        output rom_addr, car_sw, car_key, auto_active, step_pulse, loop_done
    );

    modport master (
        output auto_req, pause, rom_q,
        input  rom_addr, car_sw, car_key, auto_active, step_pulse, loop_done
    );
endinterface

// File: rtl/auto_script_sequencer.sv
// Plays the MK9 script into the car instance with per-entry dwell, pause and
// restart-from-entry-0 whenever auto mode is re-entered.
//
// state  | meaning
// MANUAL | manual controls own the display, all outputs idle
// FETCH  | rom_addr stable, waiting ROM_LAT cycles for rom_q
// LOAD   | rom_q valid, applied to car outputs at the closing edge
// HOLD   | dwell countdown (frozen while pause=1)
`timescale 1ns/1ps
module auto_script_sequencer #(
    parameter int TICK_DIV = 20000000,
    parameter int ADDR_W   = 3,
    parameter int ROM_LAT  = 1
) (
    input  logic                  ADC_CLK_10,
    input  logic                  reset,
    auto_script_sequencer_if.slave bus
);

    typedef enum logic [1:0] {MANUAL, FETCH, LOAD, HOLD} state_t;

    localparam int                TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]     TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [1:0]        FETCH_LAST = 2'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [1:0]        fetch_cnt, fetch_nxt;
    logic [TW-1:0]     tick, tick_nxt;
    logic [3:0]        units, units_nxt;
    logic [2:0]        sw, sw_nxt;
    logic [1:0]        key, key_nxt;
    logic              active, active_nxt;
    logic              step, step_nxt;
    logic              ldone, ldone_nxt;
    logic              tick_wrap;
    logic              hold_expire;

    assign tick_wrap   = !bus.pause && (tick == TICK_LAST);
    assign hold_expire = tick_wrap && (units == 4'd1);

    assign bus.rom_addr    = addr;
    assign bus.car_sw      = sw;
    assign bus.car_key     = key;
    assign bus.auto_active = active;
    assign bus.step_pulse  = step;
    assign bus.loop_done   = ldone;

    // State and registered outputs/counters; reset wins over everything.
    always_ff @(posedge ADC_CLK_10) begin
        if (reset) begin
            state     <= MANUAL;
            addr      <= '0;
            fetch_cnt <= '0;
            tick      <= '0;
            units     <= '0;
            sw        <= '0;
            key       <= 2'b11;
            active    <= 1'b0;
            step      <= 1'b0;
            ldone     <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            fetch_cnt <= fetch_nxt;
            tick      <= tick_nxt;
            units     <= units_nxt;
            sw        <= sw_nxt;
            key       <= key_nxt;
            active    <= active_nxt;
            step      <= step_nxt;
            ldone     <= ldone_nxt;
        end
    end

    // Next state; dropping auto_req beats any LOAD capture or HOLD expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            MANUAL: if (bus.auto_req) state_nxt = FETCH;
            FETCH: begin
                if (!bus.auto_req)               state_nxt = MANUAL;
                else if (fetch_cnt == FETCH_LAST) state_nxt = LOAD;
            end
            LOAD: begin
                if (!bus.auto_req) state_nxt = MANUAL;
                else               state_nxt = HOLD;
            end
            HOLD: begin
                if (!bus.auto_req)   state_nxt = MANUAL;
                else if (hold_expire) state_nxt = FETCH;
            end
            default: state_nxt = MANUAL;
        endcase
    end

    // Next values of outputs and dwell counters; pulses default low.
    always_comb begin
        addr_nxt   = addr;
        fetch_nxt  = fetch_cnt;
        tick_nxt   = tick;
        units_nxt  = units;
        sw_nxt     = sw;
        key_nxt    = key;
        active_nxt = active;
        step_nxt   = 1'b0;
        ldone_nxt  = 1'b0;
        if (state_nxt == MANUAL) begin
            addr_nxt   = '0;
            fetch_nxt  = '0;
            tick_nxt   = '0;
            units_nxt  = '0;
            sw_nxt     = '0;
            key_nxt    = 2'b11;
            active_nxt = 1'b0;
        end else begin
            case (state)
                MANUAL: begin
                    addr_nxt   = '0;
                    fetch_nxt  = '0;
                    active_nxt = 1'b1;
                end
                FETCH: fetch_nxt = fetch_cnt + 2'd1;
                LOAD: begin
                    sw_nxt    = bus.rom_q[2:0];
                    key_nxt   = {bus.rom_q[3], bus.rom_q[4]};
                    units_nxt = {1'b0, bus.rom_q[7:5]} + 4'd1;
                    tick_nxt  = '0;
                    step_nxt  = 1'b1;
                end
                HOLD: begin
                    if (!bus.pause) begin
                        if (tick_wrap) begin
                            tick_nxt  = '0;
                            units_nxt = units - 4'd1;
                            if (hold_expire) begin
                                addr_nxt  = addr + ADDR_W'(1);
                                fetch_nxt = '0;
                                ldone_nxt = (addr == ADDR_LAST);
                            end
                        end else begin
                            tick_nxt = tick + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_auto_script_sequencer.sv
// Directed bench for auto_script_sequencer with TICK_DIV=4, ROM_LAT=1.
`timescale 1ns/1ps
module tb_auto_script_sequencer;
    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 3;
    localparam int ROM_LAT  = 1;

    // obs packing: {auto_active, car_sw[2:0], car_key[1:0], step_pulse, loop_done}
    localparam logic [7:0] IDLE     = 8'b0_000_11_0_0;
    localparam logic [7:0] AUTO_IDL = 8'b1_000_11_0_0;
    localparam logic [7:0] E0_STEP  = 8'b1_101_00_1_0;
    localparam logic [7:0] E0_HOLD  = 8'b1_101_00_0_0;
    localparam logic [7:0] E1_STEP  = 8'b1_010_11_1_0;
    localparam logic [7:0] E1_HOLD  = 8'b1_010_11_0_0;
    localparam logic [7:0] E2_STEP  = 8'b1_000_00_1_0;
    localparam logic [7:0] E7_LDONE = 8'b1_000_00_0_1;

    logic       clk;
    logic       reset;
    logic [7:0] rom [8];
    logic [7:0] obs;
    int         checks;
    int         errors;

    auto_script_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    auto_script_sequencer #(
        .TICK_DIV(TICK_DIV),
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .ADC_CLK_10(clk),
        .reset     (reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

    assign obs = {bus.auto_active, bus.car_sw, bus.car_key, bus.step_pulse, bus.loop_done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (bus.step_pulse === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.auto_req = 1'b0;
        bus.pause = 1'b0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, IDLE); end
        checks++;
        if (bus.rom_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.rom_addr); end
        step();
        checks++;
        if (obs !== IDLE) begin errors++; $display("FAIL manual_idle: got %b expected %b", obs, IDLE); end
    endtask

    task automatic test_first_entry();
        bus.auto_req = 1'b1;
        step();
        checks++;
        if (obs !== AUTO_IDL) begin errors++; $display("FAIL first_fetch: got %b expected %b", obs, AUTO_IDL); end
        checks++;
        if (bus.rom_addr !== 3'd0) begin errors++; $display("FAIL first_addr: got %0d expected 0", bus.rom_addr); end
        step();
        checks++;
        if (obs !== AUTO_IDL) begin errors++; $display("FAIL first_load: got %b expected %b", obs, AUTO_IDL); end
        step();
        checks++;
        if (obs !== E0_STEP) begin errors++; $display("FAIL first_step: got %b expected %b", obs, E0_STEP); end
    endtask

    task automatic test_step_timing();
        int n;
        wait_pulse(20, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL step1_period: got %0d expected 6", n); end
        checks++;
        if (obs !== E1_STEP) begin errors++; $display("FAIL step1_values: got %b expected %b", obs, E1_STEP); end
        step();
        checks++;
        if (obs !== E1_HOLD) begin errors++; $display("FAIL step1_single: got %b expected %b", obs, E1_HOLD); end
        wait_pulse(20, n);
        checks++;
        if (n !== 9) begin errors++; $display("FAIL step2_period: got %0d expected 9", n); end
        checks++;
        if (obs !== E2_STEP) begin errors++; $display("FAIL step2_values: got %b expected %b", obs, E2_STEP); end
    endtask

    task automatic test_full_loop();
        int ld_cnt = 0;
        int ld_t = -1;
        int sp_cnt = 0;
        for (int t = 1; t <= 36; t++) begin
            step();
            if (bus.step_pulse === 1'b1) sp_cnt++;
            if (bus.loop_done === 1'b1) begin
                ld_cnt++;
                ld_t = t;
                checks++;
                if (bus.rom_addr !== 3'd0) begin errors++; $display("FAIL loop_addr: got %0d expected 0", bus.rom_addr); end
                checks++;
                if (obs !== E7_LDONE) begin errors++; $display("FAIL loop_outputs: got %b expected %b", obs, E7_LDONE); end
            end
        end
        checks++;
        if (ld_cnt !== 1) begin errors++; $display("FAIL loop_count: got %0d expected 1", ld_cnt); end
        checks++;
        if (ld_t !== 34) begin errors++; $display("FAIL loop_time: got %0d expected 34", ld_t); end
        checks++;
        if (sp_cnt !== 6) begin errors++; $display("FAIL loop_steps: got %0d expected 6", sp_cnt); end
        checks++;
        if (obs !== E0_STEP) begin errors++; $display("FAIL loop_replay: got %b expected %b", obs, E0_STEP); end
    endtask

    task automatic test_pause();
        int n;
        wait_pulse(10, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL pause_pre: got %0d expected 6", n); end
        step();
        step();
        bus.pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (obs !== E1_HOLD || bus.rom_addr !== 3'd1) begin
                errors++;
                $display("FAIL pause_frozen: got %b addr %0d expected %b addr 1", obs, bus.rom_addr, E1_HOLD);
            end
        end
        bus.pause = 1'b0;
        wait_pulse(20, n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL pause_delay: got %0d expected 8", n); end
        checks++;
        if (obs !== E2_STEP) begin errors++; $display("FAIL pause_values: got %b expected %b", obs, E2_STEP); end
    endtask

    task automatic test_abort();
        bus.auto_req = 1'b0;
        step();
        checks++;
        if (obs !== IDLE || bus.rom_addr !== 3'd0) begin
            errors++;
            $display("FAIL abort_hold: got %b addr %0d expected %b addr 0", obs, bus.rom_addr, IDLE);
        end
        bus.auto_req = 1'b1;
        step();
        step();
        checks++;
        if (obs !== AUTO_IDL) begin errors++; $display("FAIL reentry_load: got %b expected %b", obs, AUTO_IDL); end
        step();
        checks++;
        if (obs !== E0_STEP) begin errors++; $display("FAIL reentry_step: got %b expected %b", obs, E0_STEP); end
        repeat (5) step();
        checks++;
        if (obs !== E0_HOLD || bus.rom_addr !== 3'd1) begin
            errors++;
            $display("FAIL e1_load: got %b addr %0d expected %b addr 1", obs, bus.rom_addr, E0_HOLD);
        end
        bus.auto_req = 1'b0;
        step();
        checks++;
        if (obs !== IDLE || bus.rom_addr !== 3'd0) begin
            errors++;
            $display("FAIL abort_load: got %b addr %0d expected %b addr 0", obs, bus.rom_addr, IDLE);
        end
        bus.auto_req = 1'b1;
        repeat (3) step();
        checks++;
        if (obs !== E0_STEP) begin errors++; $display("FAIL abort_replay: got %b expected %b", obs, E0_STEP); end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        wait_pulse(10, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL rst_pre: got %0d expected 6", n); end
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (obs !== IDLE || bus.rom_addr !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_hold: got %b addr %0d expected %b addr 0", obs, bus.rom_addr, IDLE);
        end
        step();
        checks++;
        if (obs !== AUTO_IDL) begin errors++; $display("FAIL rst_restart: got %b expected %b", obs, AUTO_IDL); end
        step();
        step();
        checks++;
        if (obs !== E0_STEP) begin errors++; $display("FAIL rst_first_step: got %b expected %b", obs, E0_STEP); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rom[0] = 8'h05;
        rom[1] = 8'h3A;
        for (int i = 2; i < 8; i++) rom[i] = 8'h00;
        reset = 1'b1;
        bus.auto_req = 1'b0;
        bus.pause = 1'b0;
        test_reset();
        test_first_entry();
        test_step_timing();
        test_full_loop();
        test_pause();
        test_abort();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
